vga_timing_gen: RTL and testbench

- Pixel-domain video timing generator. Runs on the pixel clock produced by the pixel-clock PLL (25.2 MHz, 640x480@60).
- Gates operation on the PLL `locked` output.
- Issues pixel requests (x, y) to the framebuffer/pattern source ahead of time and re-aligns the returned colour with hsync/vsync/data-enable.
- Drives the VGA DAC/connector interface directly.

---
 rtl/vga_timing_gen.sv | 198 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Pixel-clock video timing generator: lock-filtered start, (x,y) pixel requests
// issued ahead of time, and sync/de/colour re-aligned after the client's read latency.
module vga_timing_gen #(
  parameter int       H_ACTIVE    = 640,
  parameter int       H_FP        = 16,
  parameter int       H_SYNC      = 96,
  parameter int       H_BP        = 48,
  parameter int       V_ACTIVE    = 480,
  parameter int       V_FP        = 10,
  parameter int       V_SYNC      = 2,
  parameter int       V_BP        = 33,
  parameter logic     SYNC_POL    = 1'b0,
  parameter int       PIPE_LAT    = 2,
  parameter int       LOCK_FILTER = 1024,
  parameter int       RGB_W       = 24
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             req_valid,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = 12;
  localparam int LCK_W   = $clog2(LOCK_FILTER + 1);

  typedef enum logic {
    ST_WAIT_LOCK = 1'b0,
    ST_RUN       = 1'b1
  } state_t;

  // Per-pixel control bits that travel alongside the client's read latency.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic sof;
  } ctl_t;

  state_t             state_q, state_d;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;

  logic               req_valid_q, req_valid_d;
  logic [9:0]         req_x_q, req_x_d;
  logic [9:0]         req_y_q, req_y_d;
  ctl_t               ctl_q [0:PIPE_LAT];
  ctl_t               ctl_d [0:PIPE_LAT];

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               fs_q, fs_d;

  ctl_t               cur;
  ctl_t               tail;
  logic               flush;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    flush      = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        flush   = 1'b1;
        if (!locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LCK_W'(LOCK_FILTER - 1)) begin
          state_d    = ST_RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked) begin
          // Lock loss drops every in-flight pixel so no partial line escapes.
          state_d    = ST_WAIT_LOCK;
          lock_cnt_d = '0;
          h_cnt_d    = '0;
          v_cnt_d    = '0;
          flush      = 1'b1;
        end else if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        flush   = 1'b1;
      end
    endcase

    cur     = '0;
    if (state_q == ST_RUN) begin
      cur.act = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
      cur.hs  = (h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
      cur.vs  = (v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
      cur.sof = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    tail        = ctl_q[PIPE_LAT];
    req_valid_d = cur.act;
    req_x_d     = cur.act ? h_cnt_q[9:0] : '0;
    req_y_d     = cur.act ? v_cnt_q[9:0] : '0;
    ctl_d[0]    = cur;
    for (int i = 1; i <= PIPE_LAT; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
    hsync_d = tail.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = tail.vs ? SYNC_POL : ~SYNC_POL;
    de_d    = tail.act;
    rgb_d   = tail.act ? rgb_in : '0;
    fs_d    = tail.sof;

    if (flush) begin
      req_valid_d = 1'b0;
      req_x_d     = '0;
      req_y_d     = '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        ctl_d[i] = '0;
      end
      hsync_d = ~SYNC_POL;
      vsync_d = ~SYNC_POL;
      de_d    = 1'b0;
      rgb_d   = '0;
      fs_d    = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOCK;
      lock_cnt_q  <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      req_valid_q <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        ctl_q[i] <= '0;
      end
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      req_valid_q <= req_valid_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;
  assign frame_start = fs_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (read latency 2 and 0) on a reduced
// raster, checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int LF = 1024;
  localparam int PL_A = 2;
  localparam int PL_B = 0;

  logic clk = 1'b0;
  logic rst;
  logic locked;

  logic        req_valid_a, req_valid_b;
  logic [9:0]  req_x_a, req_y_a, req_x_b, req_y_b;
  logic [23:0] rgb_in_a, rgb_in_b, rgb_out_a, rgb_out_b;
  logic        hsync_a, vsync_a, de_a, fs_a, running_a;
  logic        hsync_b, vsync_b, de_b, fs_b, running_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIPE_LAT(PL_A), .LOCK_FILTER(LF), .RGB_W(24)
  ) dut_a (
    .refclk(clk), .rst(rst), .locked(locked),
    .req_valid(req_valid_a), .req_x(req_x_a), .req_y(req_y_a),
    .rgb_in(rgb_in_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .rgb_out(rgb_out_a), .frame_start(fs_a), .running(running_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIPE_LAT(PL_B), .LOCK_FILTER(LF), .RGB_W(24)
  ) dut_b (
    .refclk(clk), .rst(rst), .locked(locked),
    .req_valid(req_valid_b), .req_x(req_x_b), .req_y(req_y_b),
    .rgb_in(rgb_in_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .rgb_out(rgb_out_b), .frame_start(fs_b), .running(running_b)
  );

  // Clients: A answers two cycles after the request, B answers combinationally.
  logic        s0_v, s1_v;
  logic [9:0]  s0_x, s0_y, s1_x, s1_y;
  logic [23:0] junk;
  initial begin
    s0_v = 1'b0; s1_v = 1'b0;
    s0_x = '0; s0_y = '0; s1_x = '0; s1_y = '0;
    junk = '0;
  end
  always @(posedge clk) begin
    s1_v <= s0_v; s1_x <= s0_x; s1_y <= s0_y;
    s0_v <= req_valid_a; s0_x <= req_x_a; s0_y <= req_y_a;
    junk <= 24'($urandom());
  end
  assign rgb_in_a = s1_v ? {s1_y[7:0], s1_x[7:0], 8'hA5} : junk;
  assign rgb_in_b = req_valid_b ? {req_y_b[7:0], req_x_b[7:0], 8'hA5} : junk;

  // Raster model: time since the run began determines the pixel at any stage.
  bit m_running = 1'b0;
  int m_p       = 0;
  int m_cnt     = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_running = 1'b0;
      m_cnt     = 0;
    end else if (!m_running) begin
      if (!locked) m_cnt = 0;
      else if (m_cnt == LF - 1) begin
        m_running = 1'b1;
        m_p       = 0;
        m_cnt     = 0;
      end else m_cnt++;
    end else if (!locked) begin
      m_running = 1'b0;
      m_cnt     = 0;
    end else begin
      m_p++;
    end
  end

  function automatic void model_px(input int lat, output bit act, output int h,
                                   output int v, output bit hs, output bit vs,
                                   output bit sof);
    int q;
    act = 0; h = 0; v = 0; hs = 0; vs = 0; sof = 0;
    if (m_running && m_p >= lat) begin
      q   = m_p - lat;
      h   = q % HT;
      v   = (q / HT) % VT;
      act = (h < HA) && (v < VA);
      hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
      vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
      sof = (h == 0) && (v == 0);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string tg, input int pl, input logic rv,
                            input logic [9:0] rx, input logic [9:0] ry,
                            input logic hs, input logic vs, input logic d,
                            input logic [23:0] rgb, input logic fs, input logic run);
    bit act, ehs, evs, esof;
    int h, v;
    logic [23:0] ergb;
    model_px(1, act, h, v, ehs, evs, esof);
    chk({tg, "_req_valid"}, 32'(rv), 32'(act));
    chk({tg, "_req_x"}, 32'(rx), act ? 32'(h) : 32'd0);
    chk({tg, "_req_y"}, 32'(ry), act ? 32'(v) : 32'd0);
    model_px(pl + 2, act, h, v, ehs, evs, esof);
    ergb = act ? {v[7:0], h[7:0], 8'hA5} : 24'h0;
    chk({tg, "_hsync"}, 32'(hs), ehs ? 32'd0 : 32'd1);
    chk({tg, "_vsync"}, 32'(vs), evs ? 32'd0 : 32'd1);
    chk({tg, "_de"}, 32'(d), 32'(act));
    chk({tg, "_rgb_out"}, 32'(rgb), 32'(ergb));
    chk({tg, "_frame_start"}, 32'(fs), 32'(esof));
    chk({tg, "_running"}, 32'(run), 32'(m_running));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("a", PL_A, req_valid_a, req_x_a, req_y_a, hsync_a, vsync_a,
                 de_a, rgb_out_a, fs_a, running_a);
      check_inst("b", PL_B, req_valid_b, req_x_b, req_y_b, hsync_b, vsync_b,
                 de_b, rgb_out_b, fs_b, running_b);
    end
  end

  // Frame-level totals on instance A, pinned to hand-computed raster numbers.
  int  f_cyc = 0, f_de = 0, f_vs = 0, f_hs = 0;
  bit  f_seen = 1'b0;
  int  n_frames = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (!running_a) begin
        f_seen = 1'b0;
      end else begin
        if (fs_a) begin
          chk("fs_rgb_origin", 32'(rgb_out_a), 32'h0000A5);
          chk("fs_de", 32'(de_a), 32'd1);
          if (f_seen) begin
            chk("frame_period", 32'(f_cyc), 32'd275);
            chk("frame_de_cycles", 32'(f_de), 32'd96);
            chk("frame_vsync_low", 32'(f_vs), 32'd50);
            chk("frame_hsync_low", 32'(f_hs), 32'd44);
            n_frames++;
          end
          f_cyc = 0; f_de = 0; f_vs = 0; f_hs = 0;
          f_seen = 1'b1;
        end
        if (f_seen) begin
          f_cyc++;
          if (de_a) f_de++;
          if (!vsync_a) f_vs++;
          if (!hsync_a) f_hs++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input int budget, output int n);
    n = 0;
    while (!running_a && n < budget) begin
      tick();
      n++;
    end
    if (!running_a) chk("wait_running_timeout", 32'(n), 32'(budget + 1));
  endtask

  int n;
  int guard;

  initial begin
    rst = 1'b1;
    locked = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    repeat (10) tick();
    chk("rst_hsync", 32'(hsync_a), 32'd1);
    chk("rst_vsync", 32'(vsync_a), 32'd1);
    chk("rst_de", 32'(de_a), 32'd0);
    chk("rst_req_valid", 32'(req_valid_a), 32'd0);
    chk("rst_running", 32'(running_a), 32'd0);

    // Lock filter from reset release.
    rst = 1'b0;
    wait_running(3000, n);
    chk("lock_after_reset", 32'(n), 32'd1024);
    chk("req_before_first_run", 32'(req_valid_a), 32'd0);
    tick();
    chk("first_req_valid", 32'(req_valid_a), 32'd1);
    chk("first_req_x", 32'(req_x_a), 32'd0);
    chk("first_req_y", 32'(req_y_a), 32'd0);

    repeat (620) tick();
    chk("frames_seen", 32'(n_frames >= 1), 32'd1);

    // Single-cycle lock glitch restarts the filter.
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (500) tick();
    chk("no_early_run", 32'(running_a), 32'd0);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_running(3000, n);
    chk("lock_after_glitch", 32'(n), 32'd1024);

    // Lock loss mid-line.
    guard = 0;
    while (!(req_valid_a && req_x_a == 10'd7 && req_y_a == 10'd3) && guard < 2000) begin
      tick();
      guard++;
    end
    chk("reach_pixel_7_3", 32'(guard < 2000), 32'd1);
    locked = 1'b0;
    tick();
    chk("loss_de", 32'(de_a), 32'd0);
    chk("loss_hsync", 32'(hsync_a), 32'd1);
    chk("loss_vsync", 32'(vsync_a), 32'd1);
    chk("loss_req_valid", 32'(req_valid_a), 32'd0);
    chk("loss_running", 32'(running_a), 32'd0);
    chk("loss_rgb", 32'(rgb_out_a), 32'd0);
    locked = 1'b1;
    wait_running(3000, n);
    chk("relock_interval", 32'(n), 32'd1024);
    tick();
    chk("relock_req_valid", 32'(req_valid_a), 32'd1);
    chk("relock_req_x", 32'(req_x_a), 32'd0);
    chk("relock_req_y", 32'(req_y_a), 32'd0);

    // Randomised interruptions: lock drops and reset pulses at arbitrary points.
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(30, 700)) tick();
      if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end else begin
        locked = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        locked = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 900)) tick();
          locked = 1'b0;
          tick();
          locked = 1'b1;
        end
      end
      wait_running(3000, n);
    end
    repeat (400) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
